fetch_stage: RTL

//  IF stage plus IF/ID pipeline register for the 16-bit 5-stage pipeline.

---
 rtl/fetch_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage : IF stage and IF/ID pipeline register of the 16-bit 5-stage
// pipeline. Owns the PC, issues word fetches to the I-cache, absorbs
// multi-cycle misses, holds on decode stalls and redirects on taken branches
// with one architectural delay slot.
//
// Optional feature macro: BRANCH_FLUSH_EN
//   defined   -> the delay-slot word is squashed (bubble, never halts)
//   undefined -> delayed-branch semantics (delay slot executes)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int                  ADDR_W    = 16,
    parameter int                  INSTR_W   = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC  = {ADDR_W{1'b0}},
    parameter logic [INSTR_W-1:0]  NOP_INSTR = {INSTR_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_rdy,
    input  logic [INSTR_W-1:0]  imem_data,
    input  logic                stall_id,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic [ADDR_W-1:0]   pc,
    output logic [INSTR_W-1:0]  ifid_instr,
    output logic [ADDR_W-1:0]   ifid_pc_plus1,
    output logic                ifid_valid,
    output logic                halted
);

`ifdef BRANCH_FLUSH_EN
    localparam logic FLUSH_EN = 1'b1;
`else
    localparam logic FLUSH_EN = 1'b0;
`endif

    localparam logic [3:0] HLT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_HALTED   = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_ifid_instr;
    logic [ADDR_W-1:0]   r_ifid_pc_plus1;
    logic                r_ifid_valid;
    logic                r_halted;
    logic                r_pend_vld;
    logic [ADDR_W-1:0]   r_pend_tgt;

    logic [ADDR_W-1:0]   w_pc_plus1;
    logic                w_deliver;
    logic                w_squash;
    logic                w_is_hlt;
    logic [ADDR_W-1:0]   w_next_pc;

    // Next-PC selection and delivery qualification for the current fetch
    always_comb begin
        w_pc_plus1 = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        w_deliver  = imem_rdy & ~stall_id;
        // A pending redirect means the word in flight is a delay slot, as
        // does a branch resolving in the very cycle the word arrives.
        w_squash   = FLUSH_EN & (r_pend_vld | branch_taken);
        w_is_hlt   = (imem_data[INSTR_W-1 -: 4] == HLT_OPCODE) & ~w_squash;
        if (r_pend_vld) begin
            w_next_pc = r_pend_tgt;
        end else if (branch_taken) begin
            w_next_pc = branch_target;
        end else begin
            w_next_pc = w_pc_plus1;
        end
    end

    // Fetch FSM, PC, pending redirect and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_FETCH;
            r_pc            <= RESET_PC;
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_pc_plus1 <= {ADDR_W{1'b0}};
            r_ifid_valid    <= 1'b0;
            r_halted        <= 1'b0;
            r_pend_vld      <= 1'b0;
            r_pend_tgt      <= {ADDR_W{1'b0}};
        end else begin
            case (r_state)
                S_FETCH, S_WAIT_MEM: begin
                    if (w_deliver) begin
                        r_ifid_instr    <= w_squash ? NOP_INSTR : imem_data;
                        r_ifid_pc_plus1 <= w_pc_plus1;
                        r_ifid_valid    <= ~w_squash;
                        r_pc            <= w_next_pc;
                        r_pend_vld      <= 1'b0;
                        if (w_is_hlt) begin
                            r_state  <= S_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_state  <= S_FETCH;
                        end
                    end else if (imem_rdy) begin
                        // Decode stalled: drop the word and refetch it.
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_WAIT_MEM;
                        if (!stall_id) begin
                            r_ifid_instr <= NOP_INSTR;
                            r_ifid_valid <= 1'b0;
                            // First redirect seen during the fetch wins; the
                            // word still in flight is its delay slot.
                            if (branch_taken && !r_pend_vld) begin
                                r_pend_vld <= 1'b1;
                                r_pend_tgt <= branch_target;
                            end else begin
                                r_pend_vld <= r_pend_vld;
                            end
                        end else begin
                            r_ifid_valid <= r_ifid_valid;
                        end
                    end
                end
                S_HALTED: begin
                    r_ifid_instr <= NOP_INSTR;
                    r_ifid_valid <= 1'b0;
                    r_halted     <= 1'b1;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_req      = ~rst & (r_state != S_HALTED);
    assign imem_addr     = r_pc;
    assign pc            = r_pc;
    assign ifid_instr    = r_ifid_instr;
    assign ifid_pc_plus1 = r_ifid_pc_plus1;
    assign ifid_valid    = r_ifid_valid;
    assign halted        = r_halted;

endmodule
